// File: rtl/mc_controller_if.sv
// Purpose: control bundle between the multicycle controller and its datapath.
//   opcode, func, mem_ready : datapath -> controller (instruction fields, memory handshake)
//   PCWriteCond .. ALUSrcA  : controller -> datapath (1-bit write enables / selects)
//   PCSource, ALUSrcB, ALUOp: controller -> datapath (2-bit select fields)
//   BranchNE, trap          : branch polarity and sticky fault flag
//   curr_state, retired     : state encoding and retired-instruction count
interface mc_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       func;
  logic             mem_ready;
  logic             PCWriteCond;
  logic             PCWrite;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             IRWrite;
  logic             RegWrite;
  logic             RegDst;
  logic             ALUSrcA;
  logic [1:0]       PCSource;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             BranchNE;
  logic             trap;
  logic [3:0]       curr_state;
  logic [CNT_W-1:0] retired;

  // Controller side.
  modport master (
    input  opcode, func, mem_ready,
    output PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUOp, BranchNE,
           trap, curr_state, retired
  );

  // Datapath side.
  modport slave (
    output opcode, func, mem_ready,
    input  PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUOp, BranchNE,
           trap, curr_state, retired
  );
endinterface

// File: rtl/mc_controller.sv
// Purpose: multicycle MIPS-style control FSM with memory wait timeout, sticky
// trap state and a retired-instruction counter.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : mc_controller_if.master (instruction fields and mem_ready in,
//         datapath controls, trap, curr_state and retired out)
module mc_controller #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WAIT_MAX = 15,
  parameter bit          EN_BNE   = 1'b1
) (
  input logic            clk,
  input logic            rst,
  mc_controller_if.master bus
);

  localparam int unsigned WCNT_W = 8;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] FN_JR   = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH  = 4'h0,
    S_DECODE = 4'h1,
    S_MADDR  = 4'h2,
    S_MEMLW  = 4'h3,
    S_MEMR   = 4'h4,
    S_MEMSW  = 4'h5,
    S_EXEC   = 4'h6,
    S_RCOMP  = 4'h7,
    S_BRANCH = 4'h8,
    S_JUMP   = 4'h9,
    S_IMM    = 4'hA,
    S_JR     = 4'hB,
    S_TRAP   = 4'hC,
    S_INIT   = 4'hF
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              trap_q;
  logic              stall;
  logic              wait_hit;

  logic              pc_write_cond_c, pc_write_c, iord_c, mem_read_c, mem_write_c;
  logic              mem_to_reg_c, ir_write_c, reg_write_c, reg_dst_c, alu_src_a_c;
  logic [1:0]        pc_source_c, alu_src_b_c, alu_op_c;
  logic              branch_ne_c;

  assign wait_hit = (wait_q == WCNT_W'(WAIT_MAX));

  // State, wait counter, retire counter and trap flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_INIT;
      wait_q    <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      trap_q    <= (state_d == S_TRAP);
    end
  end

  // Next state, wait-timeout and retirement.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    stall     = 1'b0;

    case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else               stall   = 1'b1;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW, OP_ADDI: state_d = S_MADDR;
          OP_R:                  state_d = S_EXEC;
          OP_BEQ:                state_d = S_BRANCH;
          OP_BNE:                state_d = EN_BNE ? S_BRANCH : S_TRAP;
          OP_J:                  state_d = S_JUMP;
          default:               state_d = S_TRAP;
        endcase
      end
      S_MADDR: begin
        case (bus.opcode)
          OP_LW:   state_d = S_MEMLW;
          OP_SW:   state_d = S_MEMSW;
          OP_ADDI: state_d = S_IMM;
          default: state_d = S_TRAP;
        endcase
      end
      S_MEMLW: begin
        if (bus.mem_ready) state_d = S_MEMR;
        else               stall   = 1'b1;
      end
      S_MEMSW: begin
        if (bus.mem_ready) state_d = S_FETCH;
        else               stall   = 1'b1;
      end
      S_EXEC:  state_d = (bus.func == FN_JR) ? S_JR : S_RCOMP;
      S_MEMR, S_RCOMP, S_BRANCH, S_JUMP, S_IMM, S_JR: state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // A stalled access traps once the counter has already reached the limit.
    if (stall) begin
      if (wait_hit) state_d = S_TRAP;
      else          wait_d  = wait_q + WCNT_W'(1);
    end else if (state_d != state_q) begin
      wait_d = '0;
    end

    if (state_d == S_FETCH &&
        state_q inside {S_MEMR, S_MEMSW, S_RCOMP, S_BRANCH, S_JUMP, S_IMM, S_JR}) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // Datapath control decode; INIT and TRAP leave everything deasserted.
  always_comb begin
    pc_write_cond_c = 1'b0;
    pc_write_c      = 1'b0;
    iord_c          = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    mem_to_reg_c    = 1'b0;
    ir_write_c      = 1'b0;
    reg_write_c     = 1'b0;
    reg_dst_c       = 1'b0;
    alu_src_a_c     = 1'b0;
    pc_source_c     = 2'b00;
    alu_src_b_c     = 2'b00;
    alu_op_c        = 2'b00;
    branch_ne_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        ir_write_c  = bus.mem_ready;
        pc_write_c  = bus.mem_ready;
        alu_src_b_c = 2'b01;
      end
      S_DECODE: alu_src_b_c = 2'b11;
      S_MADDR, S_IMM: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        reg_write_c = (state_q == S_IMM);
      end
      S_MEMLW: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        iord_c      = 1'b1;
        mem_read_c  = 1'b1;
      end
      S_MEMR: begin
        alu_src_a_c  = 1'b1;
        alu_src_b_c  = 2'b10;
        iord_c       = 1'b1;
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
      end
      S_MEMSW: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXEC, S_RCOMP, S_JR: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        if (state_q == S_RCOMP) begin
          reg_write_c = 1'b1;
          reg_dst_c   = 1'b1;
        end
        if (state_q == S_JR) begin
          pc_write_c  = 1'b1;
          pc_source_c = 2'b11;
        end
      end
      S_BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = 2'b01;
        pc_source_c     = 2'b01;
        pc_write_cond_c = 1'b1;
        branch_ne_c     = EN_BNE && (bus.opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_write_c  = 1'b1;
        pc_source_c = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.PCWriteCond = pc_write_cond_c;
  assign bus.PCWrite     = pc_write_c;
  assign bus.IorD        = iord_c;
  assign bus.MemRead     = mem_read_c;
  assign bus.MemWrite    = mem_write_c;
  assign bus.MemtoReg    = mem_to_reg_c;
  assign bus.IRWrite     = ir_write_c;
  assign bus.RegWrite    = reg_write_c;
  assign bus.RegDst      = reg_dst_c;
  assign bus.ALUSrcA     = alu_src_a_c;
  assign bus.PCSource    = pc_source_c;
  assign bus.ALUSrcB     = alu_src_b_c;
  assign bus.ALUOp       = alu_op_c;
  assign bus.BranchNE    = branch_ne_c;
  assign bus.trap        = trap_q;
  assign bus.curr_state  = state_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: instruction-level reference model builds the
// expected per-cycle state trace, controls are predicted per signal.
`timescale 1ns/1ps
module tb_mc_controller;

  localparam int unsigned CNT_W    = 32;
  localparam int unsigned WAIT_MAX = 15;

  localparam logic [3:0] S_FETCH = 4'h0, S_DECODE = 4'h1, S_MADDR = 4'h2, S_MEMLW = 4'h3;
  localparam logic [3:0] S_MEMR  = 4'h4, S_MEMSW  = 4'h5, S_EXEC  = 4'h6, S_RCOMP = 4'h7;
  localparam logic [3:0] S_BRANCH = 4'h8, S_JUMP = 4'h9, S_IMM = 4'hA, S_JR = 4'hB;
  localparam logic [3:0] S_TRAP  = 4'hC, S_INIT = 4'hF;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;

  typedef struct {
    logic [3:0] st;
    logic       mr;
    logic       done;
  } step_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_controller_if #(.CNT_W(CNT_W)) bus ();
  mc_controller_if #(.CNT_W(CNT_W)) bus_nb ();

  mc_controller #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX), .EN_BNE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  mc_controller #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX), .EN_BNE(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .bus(bus_nb)
  );

  int         vectors;
  int         miscompares;
  logic [CNT_W-1:0] exp_ret;
  step_t      q[$];

  function automatic logic [21:0] obs_main();
    return {bus.PCWriteCond, bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.MemtoReg, bus.IRWrite, bus.RegWrite, bus.RegDst, bus.ALUSrcA,
            bus.PCSource, bus.ALUSrcB, bus.ALUOp, bus.BranchNE, bus.trap, bus.curr_state};
  endfunction

  // Expected controls, written signal by signal from the control table.
  function automatic logic [21:0] exp_ctrl(input logic [3:0] st, input logic mr,
                                           input logic [5:0] op, input bit en_bne);
    logic pcwc, pcw, iord, mrd, mwr, m2r, irw, rw, rdst, asa, bne, trp;
    logic [1:0] pcs, asb, aop;
    pcwc = (st == S_BRANCH);
    pcw  = (st == S_JUMP) || (st == S_JR) || (st == S_FETCH && mr);
    iord = st inside {S_MEMLW, S_MEMR, S_MEMSW};
    mrd  = st inside {S_FETCH, S_MEMLW};
    mwr  = (st == S_MEMSW);
    m2r  = (st == S_MEMR);
    irw  = (st == S_FETCH) && mr;
    rw   = st inside {S_MEMR, S_RCOMP, S_IMM};
    rdst = (st == S_RCOMP);
    asa  = st inside {S_MADDR, S_MEMLW, S_MEMR, S_MEMSW, S_IMM, S_EXEC, S_RCOMP, S_JR, S_BRANCH};
    pcs  = (st == S_BRANCH) ? 2'b01 : (st == S_JUMP) ? 2'b10 : (st == S_JR) ? 2'b11 : 2'b00;
    asb  = (st == S_FETCH) ? 2'b01 : (st == S_DECODE) ? 2'b11 :
           (st inside {S_MADDR, S_MEMLW, S_MEMR, S_MEMSW, S_IMM}) ? 2'b10 : 2'b00;
    aop  = (st inside {S_EXEC, S_RCOMP, S_JR}) ? 2'b10 : (st == S_BRANCH) ? 2'b01 : 2'b00;
    bne  = (st == S_BRANCH) && (op == OP_BNE) && en_bne;
    trp  = (st == S_TRAP);
    return {pcwc, pcw, iord, mrd, mwr, m2r, irw, rw, rdst, asa, pcs, asb, aop, bne, trp, st};
  endfunction

  task automatic push(input logic [3:0] st, input logic done);
    q.push_back('{st, 1'($urandom), done});
  endtask

  // A memory access that stalls w cycles: allowed up to WAIT_MAX stalls.
  task automatic add_mem(input logic [3:0] st, input int w, input logic done, output bit trapped);
    trapped = 1'b0;
    if (w > int'(WAIT_MAX)) begin
      for (int i = 0; i <= int'(WAIT_MAX); i++) q.push_back('{st, 1'b0, 1'b0});
      for (int i = 0; i < 3; i++) push(S_TRAP, 1'b0);
      trapped = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) q.push_back('{st, 1'b0, 1'b0});
      q.push_back('{st, 1'b1, done});
    end
  endtask

  // Reference model: the state walk of one instruction.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw,
                       input int mw, output bit trapped);
    q.delete();
    add_mem(S_FETCH, fw, 1'b0, trapped);
    if (trapped) return;
    push(S_DECODE, 1'b0);
    case (op)
      OP_LW: begin
        push(S_MADDR, 1'b0);
        add_mem(S_MEMLW, mw, 1'b0, trapped);
        if (!trapped) push(S_MEMR, 1'b1);
      end
      OP_SW: begin
        push(S_MADDR, 1'b0);
        add_mem(S_MEMSW, mw, 1'b1, trapped);
      end
      OP_ADDI: begin
        push(S_MADDR, 1'b0);
        push(S_IMM, 1'b1);
      end
      OP_R: begin
        push(S_EXEC, 1'b0);
        push((fn == 6'h08) ? S_JR : S_RCOMP, 1'b1);
      end
      OP_BEQ, OP_BNE: push(S_BRANCH, 1'b1);
      OP_J:           push(S_JUMP, 1'b1);
      default: begin
        for (int i = 0; i < 3; i++) push(S_TRAP, 1'b0);
        trapped = 1'b1;
      end
    endcase
  endtask

  // Drive one instruction and compare every cycle against the model trace.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw);
    bit trapped;
    logic [21:0] got, expv;
    build(op, fn, fw, mw, trapped);
    foreach (q[i]) begin
      @(negedge clk);
      bus.opcode = op; bus.func = fn; bus.mem_ready = q[i].mr;
      #1;
      got  = obs_main();
      expv = exp_ctrl(q[i].st, q[i].mr, op, 1'b1);
      vectors++;
      if (got !== expv) begin
        miscompares++;
        $display("FAIL %s ctrl step %0d: got %h expected %h", tag, i, got, expv);
      end
      vectors++;
      if (bus.retired !== exp_ret) begin
        miscompares++;
        $display("FAIL %s retired step %0d: got %0d expected %0d", tag, i, bus.retired, exp_ret);
      end
      if (q[i].done) exp_ret++;
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    vectors++;
    if (bus.curr_state !== S_FETCH || bus.retired !== exp_ret) begin
      miscompares++;
      $display("FAIL %s idle: state %h retired %0d expected state 0 retired %0d",
               tag, bus.curr_state, bus.retired, exp_ret);
    end
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge.
  task automatic do_reset(input string tag);
    logic [21:0] init_v;
    init_v = exp_ctrl(S_INIT, 1'b0, 6'h00, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    vectors++;
    if (obs_main() !== init_v) begin
      miscompares++;
      $display("FAIL %s reset_ctrl: got %h expected %h", tag, obs_main(), init_v);
    end
    vectors++;
    if (bus.retired !== '0) begin
      miscompares++;
      $display("FAIL %s reset_retired: got %0d expected 0", tag, bus.retired);
    end
    vectors++;
    if (bus_nb.curr_state !== S_INIT || bus_nb.trap !== 1'b0) begin
      miscompares++;
      $display("FAIL %s reset_nb: state %h trap %b expected f 0", tag, bus_nb.curr_state, bus_nb.trap);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (obs_main() !== init_v) begin
      miscompares++;
      $display("FAIL %s release_hold: got %h expected %h", tag, obs_main(), init_v);
    end
    exp_ret = '0;
  endtask

  task automatic test_reset();
    do_reset("reset");
    check_idle("reset");
  endtask

  task automatic test_lw();
    do_reset("lw");
    run_instr("lw", OP_LW, 6'h00, 0, 0);
    check_idle("lw");
  endtask

  task automatic test_sw();
    do_reset("sw");
    run_instr("sw", OP_SW, 6'h00, 0, 3);
    check_idle("sw");
  endtask

  task automatic test_branch();
    do_reset("branch");
    run_instr("bne", OP_BNE, 6'h00, 1, 0);
    run_instr("beq", OP_BEQ, 6'h00, 0, 0);
    check_idle("branch");
  endtask

  task automatic test_rtype();
    do_reset("rtype");
    run_instr("jr", OP_R, 6'h08, 0, 0);
    run_instr("add", OP_R, 6'h20, 2, 0);
    run_instr("j", OP_J, 6'h00, 0, 0);
    run_instr("addi", OP_ADDI, 6'h00, 0, 0);
    check_idle("rtype");
  endtask

  task automatic test_wait_boundary();
    do_reset("wait_max");
    run_instr("lw_wmax", OP_LW, 6'h00, int'(WAIT_MAX), int'(WAIT_MAX));
    run_instr("sw_wmax", OP_SW, 6'h00, 0, int'(WAIT_MAX));
    check_idle("wait_max");
  endtask

  task automatic test_fetch_timeout();
    do_reset("fetch_to");
    run_instr("addi_pre", OP_ADDI, 6'h00, 0, 0);
    run_instr("fetch_to", OP_LW, 6'h00, int'(WAIT_MAX) + 1, 0);
    do_reset("trap_reset");
    check_idle("trap_reset");
  endtask

  task automatic test_mem_timeout();
    do_reset("mem_to");
    run_instr("sw_to", OP_SW, 6'h00, 0, int'(WAIT_MAX) + 1);
    do_reset("mem_to_rst");
  endtask

  task automatic test_illegal();
    do_reset("illegal");
    run_instr("illegal", 6'h3F, 6'h00, 0, 0);
    do_reset("illegal_rst");
  endtask

  task automatic test_bne_disabled();
    logic [3:0] nb_exp [4];
    nb_exp = '{S_FETCH, S_DECODE, S_TRAP, S_TRAP};
    do_reset("bne_off");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (bus_nb.curr_state !== nb_exp[i] || bus_nb.trap !== (nb_exp[i] == S_TRAP)) begin
        miscompares++;
        $display("FAIL bne_off step %0d: state %h trap %b expected %h", i,
                 bus_nb.curr_state, bus_nb.trap, nb_exp[i]);
      end
    end
  endtask

  // Reset while a fetch is stalled must also clear the wait counter.
  task automatic test_reset_mid_wait();
    do_reset("mid_wait");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      vectors++;
      if (bus.curr_state !== S_FETCH || bus.MemRead !== 1'b1) begin
        miscompares++;
        $display("FAIL mid_wait stall %0d: state %h MemRead %b expected 0 1", i,
                 bus.curr_state, bus.MemRead);
      end
    end
    do_reset("mid_wait_rst");
    run_instr("mid_wait_lw", OP_LW, 6'h00, int'(WAIT_MAX), 0);
    check_idle("mid_wait");
  endtask

  task automatic test_back_to_back();
    logic [5:0] op_tab [8];
    logic [5:0] fn_tab [8];
    int k, fw, mw;
    op_tab = '{OP_LW, OP_SW, OP_ADDI, OP_R, OP_R, OP_BEQ, OP_BNE, OP_J};
    fn_tab = '{6'h00, 6'h00, 6'h00, 6'h20, 6'h08, 6'h00, 6'h00, 6'h00};
    do_reset("b2b");
    for (int n = 0; n < 40; n++) begin
      k  = int'($urandom_range(7, 0));
      fw = ($urandom_range(9, 0) == 0) ? int'(WAIT_MAX) : int'($urandom_range(3, 0));
      mw = ($urandom_range(9, 0) == 0) ? int'(WAIT_MAX) : int'($urandom_range(3, 0));
      run_instr("b2b", op_tab[k], fn_tab[k], fw, mw);
    end
    check_idle("b2b");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors        = 0;
    miscompares    = 0;
    exp_ret        = '0;
    rst            = 1'b0;
    bus.opcode     = 6'h00;
    bus.func       = 6'h00;
    bus.mem_ready  = 1'b0;
    bus_nb.opcode    = OP_BNE;
    bus_nb.func      = 6'h00;
    bus_nb.mem_ready = 1'b1;

    test_reset();
    test_lw();
    test_sw();
    test_branch();
    test_rtype();
    test_wait_boundary();
    test_fetch_timeout();
    test_mem_timeout();
    test_illegal();
    test_bne_disabled();
    test_reset_mid_wait();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
